seq_multiplier: RTL and testbench
=================================

# seq_multiplier

Parametrised, multi-cycle two's-complement/unsigned integer multiplier with valid/ready handshakes on input and output. It is the sequential, width-generic successor to our fixed 8x8 combinational carry-save multiplier. It trades area for latency: it retires BITS_PER_CYCLE multiplier bits per clock into a 2*WIDTH accumulator. It sits between a producer and a consumer that both speak valid/ready, and it exerts backpressure in both directions.

## Interface
- WIDTH, 8: operand width in bits; legal values are 4 to 32.
- BITS_PER_CYCLE, 1: multiplier bits consumed per RUN cycle; must divide WIDTH; legal values are 1, 2 and 4.
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled at acceptance.
- x  input  WIDTH  multiplicand.
- y  input  WIDTH  multiplier.
- out_valid  output  1  product is valid; high only in DONE.
- out_ready  input  1  consumer accepts the product.
- product  output  2*WIDTH  x*y, full width, exact in both modes.
- busy  output  1  high in RUN or DONE.

## Operation
- N = WIDTH / BITS_PER_CYCLE compute steps per operation.
- States are IDLE, RUN and DONE. Reset enters IDLE.
- IDLE: in_ready=1. When in_valid=1 at an edge, the block latches x, y and signed_mode, clears the accumulator, sets step counter=0 and moves to RUN.
- RUN: each cycle consumes the next BITS_PER_CYCLE bits of y, LSB first. It adds the corresponding shifted partial products of x into the accumulator. When the counter reaches N-1, that edge moves the block to DONE and loads the result into product.
- DONE: out_valid=1 and product is held stable. When out_ready=1 at an edge, the block returns to IDLE and out_valid drops.
- Arithmetic, unsigned mode: x and y are zero-extended, and the result equals x*y, which always fits in 2*WIDTH bits.
- Arithmetic, signed mode: x is sign-extended to 2*WIDTH bits for every partial product. The partial product for y[WIDTH-1] is subtracted rather than added (two's-complement weight -2^(WIDTH-1)). The result equals the signed product, exact in 2*WIDTH bits, including -2^(WIDTH-1) * -2^(WIDTH-1).
- Accumulator arithmetic is modulo 2^(2*WIDTH). No carry-out or overflow flag exists, and none is needed.
- in_valid outside IDLE is ignored. Operands are not re-sampled mid-operation, so the producer may change x, y and signed_mode freely once the handshake completes.
- out_ready outside DONE is ignored.
- rst_n=0 at any edge, including mid-RUN or in DONE, aborts the operation. The state returns to IDLE and no partial result is ever presented.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, product=0, state=IDLE, counter=0.
- in_ready, out_valid and busy are decoded from registered state only, with no combinational path from any input.
- Input handshake completes at edge E. out_valid first rises after edge E+N, so latency is N cycles from acceptance. For WIDTH=8 this is 8, 4 and 2 cycles for BITS_PER_CYCLE of 1, 2 and 4.
- If out_ready is held high, the output handshake completes at edge E+N+1. in_ready is then high in the following cycle, giving a sustained throughput of one result per N+2 cycles.
- If out_ready is held low, DONE persists indefinitely with product unchanged.
- product is registered. It changes only on entry to DONE or on reset, and otherwise holds its last value, including while in IDLE.

## Test plan
- WIDTH=8, BITS_PER_CYCLE=1, unsigned, x=255, y=255 -> out_valid rises 8 cycles after acceptance with product=16'hFE01.
- Signed, x=8'h80, y=8'h80 -> product=16'h4000. Signed, x=8'hFF, y=8'h01 -> product=16'hFFFF. Unsigned, x=8'hFF, y=8'h01 -> product=16'h00FF.
- Repeat the first case with BITS_PER_CYCLE=2 and 4 -> identical product, with latencies of 4 and 2 cycles respectively.
- Hold out_ready=0 for 10 cycles in DONE, and toggle x, y and in_valid during that window -> product is stable, in_ready stays 0, and the result is accepted on the first cycle out_ready=1.
- Assert rst_n=0 for one edge in the 3rd RUN cycle -> next cycle shows IDLE, out_valid=0, product=0. A fresh operation, signed -3*5, then yields 16'hFFF1.
- Run a random back-to-back stream of 1000 operations with random valid/ready gaps, in both modes and for WIDTH in {4, 8, 16} -> every product matches a reference model, and no product is lost or duplicated.

Source files
------------

// File: rtl/seq_multiplier.sv
// seq_multiplier
//   Multi-cycle WIDTH x WIDTH integer multiplier, unsigned or two's-complement.
//   It retires BITS_PER_CYCLE multiplier bits per clock into a 2*WIDTH
//   accumulator. Input and output each use a valid/ready handshake.
//
// Parameters
//   WIDTH          operand width, 4..32
//   BITS_PER_CYCLE multiplier bits consumed per RUN cycle (1, 2 or 4); divides WIDTH
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset; aborts any operation
//   in_valid     operands/mode valid (ignored outside IDLE)
//   in_ready     high only in IDLE
//   signed_mode  1 = two's-complement, 0 = unsigned; sampled at acceptance
//   x, y         multiplicand, multiplier
//   out_valid    high only in DONE
//   out_ready    consumer takes the product (ignored outside DONE)
//   product      registered 2*WIDTH result, held until the next DONE entry or reset
//   busy         high in RUN or DONE

`timescale 1ns/1ps

module seq_multiplier #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int PW = 2 * WIDTH;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [PW-1:0]   mcand;     // extended multiplicand, pre-shifted to the current step
    logic [WIDTH-1:0] mplier;   // remaining multiplier bits, next chunk in the LSBs
    logic            smode;
    logic [PW-1:0]   acc;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   step_sum;
    logic [PW-1:0]   pp;
    logic            last_step;

    assign last_step = (cnt == LAST);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs, decoded from registered state only
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case leaves it unassigned and infers a latch.
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One step of partial products. In signed mode the top multiplier bit
    // carries weight -2^(WIDTH-1), so its partial product is subtracted; that
    // bit is always the top bit of the final chunk.
    always_comb begin
        // NOTE: blocking assignments here so each loop iteration sees the sum
        // built by the previous one; state registers use non-blocking only.
        step_sum = acc;
        pp       = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            pp = mplier[j] ? (mcand << j) : '0;
            if (smode && last_step && (j == BITS_PER_CYCLE - 1)) begin
                step_sum = step_sum - pp;
            end else begin
                step_sum = step_sum + pp;
            end
        end
    end

    // Datapath
    always_ff @(posedge clk) begin
        // NOTE: the datapath is reset too, because product must read 0 after
        // reset and an aborted operation must leave nothing behind.
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            smode   <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= signed_mode ? {{WIDTH{x[WIDTH-1]}}, x}
                                              : {{WIDTH{1'b0}}, x};
                        mplier <= y;
                        smode  <= signed_mode;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    acc    <= step_sum;
                    mcand  <= mcand << BITS_PER_CYCLE;
                    mplier <= mplier >> BITS_PER_CYCLE;
                    cnt    <= cnt + 1'b1;
                    if (last_step) product <= step_sum;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Testbench for seq_multiplier. Five instances cover WIDTH 4/8/16 and
// BITS_PER_CYCLE 1/2/4. Drivers push expected results into a shared
// scoreboard; one monitor per instance pops and compares whenever out_valid
// is seen, and also checks the acceptance-to-valid latency.

`timescale 1ns/1ps

module tb_seq_multiplier;

    localparam int NDUT = 5;
    localparam int CW[NDUT] = '{8, 8, 8, 16, 4};
    localparam int CB[NDUT] = '{1, 2, 4, 2, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [NDUT-1:0] iv_v;
    logic [NDUT-1:0] sm_v;
    logic [NDUT-1:0] or_v;
    logic [15:0]     x_a [NDUT];
    logic [15:0]     y_a [NDUT];
    wire  [NDUT-1:0] rdy_v;
    wire  [NDUT-1:0] ov_v;
    wire  [NDUT-1:0] busy_v;
    wire  [15:0]     p0, p1, p2;
    wire  [31:0]     p3;
    wire  [7:0]      p4;

    seq_multiplier #(.WIDTH(CW[0]), .BITS_PER_CYCLE(CB[0])) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_v[0]), .in_ready(rdy_v[0]),
        .signed_mode(sm_v[0]), .x(x_a[0][7:0]), .y(y_a[0][7:0]),
        .out_valid(ov_v[0]), .out_ready(or_v[0]), .product(p0), .busy(busy_v[0]));

    seq_multiplier #(.WIDTH(CW[1]), .BITS_PER_CYCLE(CB[1])) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_v[1]), .in_ready(rdy_v[1]),
        .signed_mode(sm_v[1]), .x(x_a[1][7:0]), .y(y_a[1][7:0]),
        .out_valid(ov_v[1]), .out_ready(or_v[1]), .product(p1), .busy(busy_v[1]));

    seq_multiplier #(.WIDTH(CW[2]), .BITS_PER_CYCLE(CB[2])) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_v[2]), .in_ready(rdy_v[2]),
        .signed_mode(sm_v[2]), .x(x_a[2][7:0]), .y(y_a[2][7:0]),
        .out_valid(ov_v[2]), .out_ready(or_v[2]), .product(p2), .busy(busy_v[2]));

    seq_multiplier #(.WIDTH(CW[3]), .BITS_PER_CYCLE(CB[3])) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_v[3]), .in_ready(rdy_v[3]),
        .signed_mode(sm_v[3]), .x(x_a[3]), .y(y_a[3]),
        .out_valid(ov_v[3]), .out_ready(or_v[3]), .product(p3), .busy(busy_v[3]));

    seq_multiplier #(.WIDTH(CW[4]), .BITS_PER_CYCLE(CB[4])) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_v[4]), .in_ready(rdy_v[4]),
        .signed_mode(sm_v[4]), .x(x_a[4][3:0]), .y(y_a[4][3:0]),
        .out_valid(ov_v[4]), .out_ready(or_v[4]), .product(p4), .busy(busy_v[4]));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;   // number of rising edges so far
    int hold_left [NDUT];

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          idx;
        logic [31:0] val;
        int          edge_no;   // rising edge at which the operands were accepted
    } exp_t;

    exp_t sb [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] prod(input int i);
        case (i)
            0:       return {16'b0, p0};
            1:       return {16'b0, p1};
            2:       return {16'b0, p2};
            3:       return p3;
            default: return {24'b0, p4};
        endcase
    endfunction

    function automatic logic [15:0] mask(input int i);
        return 16'((32'd1 << CW[i]) - 32'd1);
    endfunction

    // Reference: interpret operands as integers of width w and multiply.
    function automatic logic [31:0] ref_mul(input int w, input logic sm,
                                            input logic [15:0] xv, input logic [15:0] yv);
        longint a, b, p, full;
        full = longint'(1) << w;
        a = longint'(xv) & (full - 1);
        b = longint'(yv) & (full - 1);
        if (sm && a >= (full >> 1)) a = a - full;
        if (sm && b >= (full >> 1)) b = b - full;
        p = a * b;
        p = p & ((longint'(1) << (2 * w)) - 1);
        return p[31:0];
    endfunction

    function automatic logic [15:0] pick(input int i);
        case ($urandom_range(0, 5))
            0:       return 16'd0;
            1:       return mask(i);
            2:       return 16'(32'd1 << (CW[i] - 1));
            3:       return 16'd1;
            default: return 16'($urandom) & mask(i);
        endcase
    endfunction

    // Present one operation and wait for it to be accepted.
    task automatic issue(input int i, input logic sm, input logic [15:0] xv,
                         input logic [15:0] yv, input logic [31:0] expv, input bit push);
        int budget;
        budget = 0;
        @(negedge clk);
        iv_v[i] = 1'b1;
        sm_v[i] = sm;
        x_a[i]  = xv;
        y_a[i]  = yv;
        while (!rdy_v[i] && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!rdy_v[i]) begin
            check($sformatf("dut%0d_accept_timeout", i), 32'(rdy_v[i]), 32'd1);
            iv_v[i] = 1'b0;
            return;
        end
        if (push) sb.push_back('{i, expv, cyc + 1});
        @(posedge clk);
        #1;
        // Scramble operands: the block must not re-sample them.
        iv_v[i] = 1'b0;
        sm_v[i] = 1'($urandom);
        x_a[i]  = 16'($urandom);
        y_a[i]  = 16'($urandom);
    endtask

    task automatic monitor(input int i);
        bit seen;
        bit consumed;
        int k;
        seen     = 1'b0;
        consumed = 1'b0;
        forever begin
            @(negedge clk);
            if (consumed) begin
                check($sformatf("dut%0d_valid_drop", i), 32'(ov_v[i]), 32'd0);
                consumed = 1'b0;
            end
            if (ov_v[i]) begin
                k = -1;
                for (int j = 0; j < sb.size(); j++) begin
                    if (k < 0 && sb[j].idx == i) k = j;
                end
                if (k < 0) begin
                    check($sformatf("dut%0d_unexpected_out", i), 32'(ov_v[i]), 32'd0);
                    or_v[i] = 1'b1;
                end else begin
                    if (!seen) begin
                        check($sformatf("dut%0d_latency", i),
                              32'(cyc - sb[k].edge_no), 32'(CW[i] / CB[i]));
                        seen = 1'b1;
                    end
                    check($sformatf("dut%0d_product", i), prod(i), sb[k].val);
                    if (hold_left[i] > 0) begin
                        hold_left[i]--;
                        or_v[i] = 1'b0;
                    end else begin
                        or_v[i] = ($urandom_range(0, 3) != 0);
                    end
                    if (or_v[i]) begin
                        sb.delete(k);
                        seen     = 1'b0;
                        consumed = 1'b1;
                    end
                end
            end else begin
                or_v[i] = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (sb.size() != 0 && b < 1000) begin
            @(negedge clk);
            b++;
        end
        check("drain", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_random(input int i, input int n);
        for (int t = 0; t < n; t++) begin
            logic        sm;
            logic [15:0] xv;
            logic [15:0] yv;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            sm = 1'($urandom);
            xv = pick(i);
            yv = pick(i);
            issue(i, sm, xv, yv, ref_mul(CW[i], sm, xv, yv), 1'b1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        rst_n = 1'b0;
        iv_v  = '0;
        sm_v  = '0;
        or_v  = '0;
        for (int i = 0; i < NDUT; i++) begin
            x_a[i]       = '0;
            y_a[i]       = '0;
            hold_left[i] = 0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state of every instance
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("dut%0d_rst_in_ready", i), 32'(rdy_v[i]), 32'd1);
            check($sformatf("dut%0d_rst_out_valid", i), 32'(ov_v[i]), 32'd0);
            check($sformatf("dut%0d_rst_busy", i), 32'(busy_v[i]), 32'd0);
            check($sformatf("dut%0d_rst_product", i), prod(i), 32'd0);
        end

        for (int i = 0; i < NDUT; i++) begin
            automatic int ii = i;
            fork
                monitor(ii);
            join_none
        end

        // Directed corner cases; the 255*255 case also on BITS_PER_CYCLE 2 and 4
        fork
            begin
                issue(0, 1'b0, 16'h00FF, 16'h00FF, 32'h0000_FE01, 1'b1);
                issue(0, 1'b1, 16'h0080, 16'h0080, 32'h0000_4000, 1'b1);
                issue(0, 1'b1, 16'h00FF, 16'h0001, 32'h0000_FFFF, 1'b1);
                issue(0, 1'b0, 16'h00FF, 16'h0001, 32'h0000_00FF, 1'b1);
            end
            issue(1, 1'b0, 16'h00FF, 16'h00FF, 32'h0000_FE01, 1'b1);
            issue(2, 1'b0, 16'h00FF, 16'h00FF, 32'h0000_FE01, 1'b1);
        join
        drain();

        // Hold DONE for 10 cycles while the producer side toggles
        hold_left[0] = 10;
        issue(0, 1'b0, 16'd200, 16'd150, 32'd30000, 1'b1);
        b = 0;
        @(negedge clk);
        while (!ov_v[0] && b < 50) begin
            @(negedge clk);
            b++;
        end
        check("hold_valid_seen", 32'(ov_v[0]), 32'd1);
        for (int t = 0; t < 10; t++) begin
            check("hold_in_ready", 32'(rdy_v[0]), 32'd0);
            iv_v[0] = 1'($urandom);
            sm_v[0] = 1'($urandom);
            x_a[0]  = 16'($urandom);
            y_a[0]  = 16'($urandom);
            @(negedge clk);
        end
        iv_v[0] = 1'b0;
        drain();

        // Reset during the third RUN cycle aborts the operation
        issue(0, 1'b0, 16'd37, 16'd91, 32'd0, 1'b0);
        repeat (3) @(negedge clk);
        check("abort_busy_before", 32'(busy_v[0]), 32'd1);
        check("abort_in_ready_before", 32'(rdy_v[0]), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_in_ready", 32'(rdy_v[0]), 32'd1);
        check("abort_out_valid", 32'(ov_v[0]), 32'd0);
        check("abort_busy", 32'(busy_v[0]), 32'd0);
        check("abort_product", prod(0), 32'd0);
        issue(0, 1'b1, 16'h00FD, 16'h0005, 32'h0000_FFF1, 1'b1);
        drain();

        // Random back-to-back streams on every configuration
        fork
            run_random(0, 300);
            run_random(1, 300);
            run_random(2, 300);
            run_random(3, 300);
            run_random(4, 300);
        join
        drain();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
